// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder slice.
//   - RV32I load/store funct3 width codes
//   - FSM state enum for the responder handshake
//   - captured request record (write, addr, wdata, funct3)
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for 32-bit RV32I memory accesses.
// Store side: byte enables plus store data moved up into the addressed lanes.
// Load side: addressed bytes moved down to lane 0, then sign/zero extended.
// The caller hands in an already-legal funct3 and a size-aligned offset.
//
// Ports
//   i_offset  [1:0]  byte lane of the access
//   i_funct3  [2:0]  width code (B/H/W, BU/HU for loads)
//   i_wdata   [31:0] store data, lane-0 aligned
//   i_rword   [31:0] raw word read from the array
//   o_be      [3:0]  store byte enables
//   o_wdata   [31:0] store data shifted into the target lanes
//   o_rdata   [31:0] extended load data
// ---------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;

    assign w_shamt = {i_offset, 3'b000};

    // Width decode drives both directions; word access is the fallback.
    always_comb begin
        w_shifted = i_rword >> w_shamt;
        o_wdata   = i_wdata << w_shamt;
        o_be      = 4'b1111;
        o_rdata   = w_shifted;
        case (i_funct3)
            F3_B: begin
                o_be    = 4'b0001 << i_offset;
                o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_BU: begin
                o_be    = 4'b0001 << i_offset;
                o_rdata = {24'h000000, w_shifted[7:0]};
            end
            F3_H: begin
                o_be    = 4'b0011 << i_offset;
                o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_HU: begin
                o_be    = 4'b0011 << i_offset;
                o_rdata = {16'h0000, w_shifted[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_rdata = w_shifted;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side end of the RV32I core load/store path. Accepts one request at a
// time over valid/ready, performs the access READ_LATENCY cycles after the
// accept edge, and holds the response until the requester takes it.
//
// Optional build macro: DMEM_ALIGN_CHECK_EN
//   defined   -> misaligned / out-of-range / illegal funct3 flagged on
//                rsp_error; such accesses write nothing and return 0
//   undefined -> rsp_error is always 0, word index wraps modulo MEM_DEPTH,
//                misaligned accesses are force-aligned, illegal funct3 acts
//                as a word access
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_write                1 = store, 0 = load
//   req_addr   [31:0]        byte address
//   req_wdata  [DW-1:0]      store data, lane-0 aligned
//   req_funct3 [2:0]         RV32I width code
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata  [DW-1:0]      extended load data (0 for stores and errors)
//   rsp_error                access error flag
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error
);

    localparam int         IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_cnt;
    dmem_req_t             r_req;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_commit;
    logic [29:0]           w_word_idx;
    logic [1:0]            w_off;
    logic                  w_legal;
    logic [2:0]            w_f3_eff;
    logic [1:0]            w_off_eff;
    logic                  w_error;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rword;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata_sh;
    logic [DATA_WIDTH-1:0] w_rdata_ext;

    // Handshake FSM: ready only in IDLE, the access fires on the edge where
    // the latency counter reads zero, and RESP waits for the requester.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_commit  = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == 3'd0) begin
                    w_commit = 1'b1;
                    w_next   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request decode. Funct3 is normalised to a legal width so the lane
    // aligner never sees an illegal code, and the byte offset is rounded
    // down to the access size; an aligned request is unaffected by either.
    always_comb begin
        w_word_idx = r_req.addr[31:2];
        w_off      = r_req.addr[1:0];
        if (r_req.write) begin
            w_legal = (r_req.funct3 == F3_B) || (r_req.funct3 == F3_H) ||
                      (r_req.funct3 == F3_W);
        end else begin
            w_legal = (r_req.funct3 == F3_B)  || (r_req.funct3 == F3_H)  ||
                      (r_req.funct3 == F3_W)  || (r_req.funct3 == F3_BU) ||
                      (r_req.funct3 == F3_HU);
        end
        w_f3_eff = w_legal ? r_req.funct3 : F3_W;
        case (w_f3_eff[1:0])
            2'b00:   w_off_eff = w_off;
            2'b01:   w_off_eff = {w_off[1], 1'b0};
            default: w_off_eff = 2'b00;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_error = !w_legal ||
                     (w_word_idx >= 30'(MEM_DEPTH)) ||
                     ((w_f3_eff[1:0] == 2'b01) && w_off[0]) ||
                     ((w_f3_eff[1:0] == 2'b10) && (w_off != 2'b00));
    assign w_idx   = w_word_idx[IDX_W-1:0];
`else
    assign w_error = 1'b0;
    assign w_idx   = IDX_W'(w_word_idx % 30'(MEM_DEPTH));
`endif

    assign w_rword = r_mem[w_idx];

    dmem_lane_align u_lane_align (
        .i_offset (w_off_eff),
        .i_funct3 (w_f3_eff),
        .i_wdata  (r_req.wdata),
        .i_rword  (w_rword),
        .o_be     (w_be),
        .o_wdata  (w_wdata_sh),
        .o_rdata  (w_rdata_ext)
    );

    // Control state and registered response; the request is captured on
    // the accept edge and never changes until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_req   <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_req <= '{write:  req_write,
                           addr:   req_addr,
                           wdata:  req_wdata,
                           funct3: req_funct3};
                r_cnt <= CNT_INIT;
            end else if ((r_state == ACCESS) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_commit) begin
                r_rdata <= (r_req.write || w_error) ? '0 : w_rdata_ext;
                r_error <= w_error;
            end
        end
    end

    // Array storage is deliberately not reset. A commit edge that coincides
    // with reset must not write, hence the explicit rst gate.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_req.write && !w_error) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. A byte-array model predicts every
// response; a compare process checks the held response on every cycle it is
// valid, and directed literal checks pin the model to known values.
// Honours DMEM_ALIGN_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic [2:0]    req_funct3;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;

    int            total = 0;
    int            bad   = 0;

    logic [7:0]    mdl [DEPTH*4];
    logic [31:0]   expRdata;
    logic          expError;
    bit            expPending = 0;

    dmem_responder #(
        .DATA_WIDTH   (DW),
        .MEM_DEPTH    (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so a stuck handshake can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference: works out access size, alignment and
    // extension directly from the RV32I rules, one byte at a time.
    function automatic void modelOp(input logic w, input logic [31:0] a, input logic [31:0] d,
                                    input logic [2:0] f, output logic [31:0] rd, output logic er);
        bit          legal;
        bit          sgn;
        int          size;
        longint      idx;
        int          off;
        int          base;
        logic [31:0] v;
        legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal)              size = 4;
        else if (f[1:0] == 2'd0) size = 1;
        else if (f[1:0] == 2'd1) size = 2;
        else                     size = 4;
        sgn = !w && (f == 3'd0 || f == 3'd1);
        idx = longint'(a >> 2);
        off = int'(a[1:0]);
        er  = 1'b0;
        rd  = 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (!legal || idx >= DEPTH || (off % size) != 0) er = 1'b1;
`endif
        if (er) return;
        idx  = idx % DEPTH;
        off  = off - (off % size);
        base = int'(idx) * 4 + off;
        if (w) begin
            for (int i = 0; i < size; i++) mdl[base+i] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | ({24'h0, mdl[base+i]} << (8*i));
            if (sgn && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
            rd = v;
        end
    endfunction

    // Per-cycle compare: any valid response must match the model and must
    // block new requests; a response nobody is waiting for is an error.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (!expPending) begin
                checkOutput("unexpected_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            end else begin
                checkOutput("rsp_rdata", rsp_rdata, expRdata);
                checkOutput("rsp_error", {31'h0, rsp_error}, {31'h0, expError});
                checkOutput("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
            end
        end
    end

    // One full transaction: present, wait for accept, wait for the response
    // with junk on the request bus, hold the response, then hand it off.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f, input int hold,
                                 output logic [31:0] gotData, output logic gotErr);
        int n;
        gotData = 32'h0;
        gotErr  = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_funct3 = f;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", {31'h0, req_ready}, 32'h1);
            req_valid = 1'b0;
            return;
        end
        modelOp(w, a, d, f, expRdata, expError);
        @(posedge clk);
        expPending = 1'b1;
        n = 0;
        while (1) begin
            #1;
            req_valid  = 1'($urandom_range(0, 1));
            req_write  = 1'($urandom_range(0, 1));
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_funct3 = 3'($urandom_range(0, 7));
            rsp_ready  = 1'($urandom_range(0, 1));
            @(posedge clk);
            n++;
            #1;
            if (rsp_valid || n >= 20) break;
        end
        rsp_ready = 1'b0;
        checkOutput("rsp_latency", 32'(n), 32'(LAT));
        if (!rsp_valid) begin
            expPending = 1'b0;
            req_valid  = 1'b0;
            return;
        end
        gotData = rsp_rdata;
        gotErr  = rsp_error;
        repeat (hold) begin
            @(posedge clk);
            #1;
            checkOutput("rsp_valid_held", {31'h0, rsp_valid}, 32'h1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        expPending = 1'b0;
        #1;
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_handoff", {31'h0, rsp_valid}, 32'h0);
        checkOutput("req_ready_after_handoff", {31'h0, req_ready}, 32'h1);
    endtask

    // Reset lands on the commit edge of a store: nothing may be written and
    // no response may appear.
    task automatic resetDuringAccess();
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'hAAAAAAAA;
        req_funct3 = 3'b010;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_test_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("rst_mid_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            checkOutput("rst_rsp_never", {31'h0, rsp_valid}, 32'h0);
        end
    endtask

    initial begin
        logic [31:0] got;
        logic        gErr;
        logic        w;
        logic [31:0] a;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h0);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_rsp_error", {31'h0, rsp_error}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i * 4), $urandom, 3'b010, 0, got, gErr);
        end

        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, got, gErr);
        checkOutput("sw_rdata_zero", got, 32'h0);
        applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 1, got, gErr);
        checkOutput("lw_0x10", got, 32'hDEADBEEF);
        checkOutput("lw_0x10_err", {31'h0, gErr}, 32'h0);
        applyStimulus(1'b0, 32'h13, 32'h0, 3'b000, 0, got, gErr);
        checkOutput("lb_0x13", got, 32'hFFFFFFDE);
        applyStimulus(1'b0, 32'h13, 32'h0, 3'b100, 0, got, gErr);
        checkOutput("lbu_0x13", got, 32'h000000DE);
        applyStimulus(1'b0, 32'h12, 32'h0, 3'b001, 0, got, gErr);
        checkOutput("lh_0x12", got, 32'hFFFFDEAD);
        applyStimulus(1'b0, 32'h10, 32'h0, 3'b101, 0, got, gErr);
        checkOutput("lhu_0x10", got, 32'h0000BEEF);
        applyStimulus(1'b1, 32'h11, 32'h55, 3'b000, 0, got, gErr);
        applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 0, got, gErr);
        checkOutput("lw_after_sb", got, 32'hDEAD55EF);
        applyStimulus(1'b1, 32'h12, 32'h1234, 3'b001, 0, got, gErr);
        applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 0, got, gErr);
        checkOutput("lw_after_sh", got, 32'h123455EF);

`ifdef DMEM_ALIGN_CHECK_EN
        applyStimulus(1'b0, 32'h11, 32'h0, 3'b010, 0, got, gErr);
        checkOutput("lw_misaligned_err", {31'h0, gErr}, 32'h1);
        checkOutput("lw_misaligned_data", got, 32'h0);
        applyStimulus(1'b1, 32'h400, 32'h0BADF00D, 3'b010, 0, got, gErr);
        checkOutput("sw_oor_err", {31'h0, gErr}, 32'h1);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 0, got, gErr);
`else
        applyStimulus(1'b0, 32'h11, 32'h0, 3'b010, 0, got, gErr);
        checkOutput("lw_misaligned_forced", got, 32'h123455EF);
        checkOutput("lw_misaligned_noerr", {31'h0, gErr}, 32'h0);
        applyStimulus(1'b1, 32'h400, 32'h0BADF00D, 3'b010, 0, got, gErr);
        applyStimulus(1'b0, 32'h0, 32'h0, 3'b010, 0, got, gErr);
        checkOutput("lw_wrapped", got, 32'h0BADF00D);
`endif

        applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 5, got, gErr);

        resetDuringAccess();
        applyStimulus(1'b0, 32'h20, 32'h0, 3'b010, 0, got, gErr);

        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else                           a = 32'($urandom_range(0, DEPTH*4 - 1));
            applyStimulus(w, a, $urandom, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3), got, gErr);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
